// File: rtl/bc_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bc_pkg : shared basic-computer register defaults and command encoding
// rev 1.0
// ---------------------------------------------------------------------------
package bc_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_BUS_W  = 16;

   typedef enum logic [1:0] {
      CMD_NONE = 2'd0,
      CMD_LOAD = 2'd1,
      CMD_CLR  = 2'd2,
      CMD_INC  = 2'd3
   } cmd_e;

endpackage
`default_nettype wire

// File: rtl/eight_bit_io_register_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_counter : up-counter that sticks at all-ones instead of wrapping
// rev 1.0
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (en && (count != {WIDTH{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/eight_bit_io_register.sv
`default_nettype none
// ---------------------------------------------------------------------------
// eight_bit_io_register : load-only INPR/OUTR register; clr/inc are flagged
// rev 1.0
// ---------------------------------------------------------------------------
module eight_bit_io_register
   import bc_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int BUS_W    = DEF_BUS_W,
   parameter int ERRCNT_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic                inc,
   input  logic                clr,
   input  logic [BUS_W-1:0]    in_data,
   output logic [DATA_W-1:0]   out_data,
   output logic                cmd_err,
   output logic [ERRCNT_W-1:0] err_count
);

   logic illegal;

   assign illegal = inc | clr;

   // Load still wins when it coincides with an illegal command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         cmd_err  <= 1'b0;
      end else begin
         cmd_err <= illegal;
         if (load) begin
            out_data <= in_data[DATA_W-1:0];
         end
      end
   end

   sat_counter #(
      .WIDTH (ERRCNT_W)
   ) u_err_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (illegal),
      .count (err_count)
   );

   generate
      if (BUS_W > DATA_W) begin : g_bus_hi
         logic unused_bus_hi;
         assign unused_bus_hi = ^in_data[BUS_W-1:DATA_W];
      end
   endgenerate

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst_n && illegal) begin
         $display("Erronous command on input-output register");
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_eight_bit_io_register.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_eight_bit_io_register : randomized self-checking bench with reference model
// rev 1.0
// ---------------------------------------------------------------------------
module tb_eight_bit_io_register;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load, inc, clr;
   logic [15:0] in_data;
   logic [7:0]  out_data;
   logic        cmd_err;
   logic [7:0]  err_count;

   int checks = 0;
   int errors = 0;

   // reference model state
   int exp_data;
   int exp_cnt;
   int exp_err;

   always #10 clk = ~clk;

   eight_bit_io_register #(
      .DATA_W   (8),
      .BUS_W    (16),
      .ERRCNT_W (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .inc       (inc),
      .clr       (clr),
      .in_data   (in_data),
      .out_data  (out_data),
      .cmd_err   (cmd_err),
      .err_count (err_count)
   );

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".data"}, int'(out_data), exp_data);
      check({tag, ".err"},  int'(cmd_err),  exp_err);
      check({tag, ".cnt"},  int'(err_count), exp_cnt);
   endtask

   // Drive one command at negedge, apply the model, sample 2 ns after posedge.
   task automatic cycle(input logic l, input logic i, input logic c,
                        input logic [15:0] d, input string tag);
      @(negedge clk);
      load = l; inc = i; clr = c; in_data = d;
      if (l) exp_data = d % 256;
      exp_err = (i || c) ? 1 : 0;
      if ((i || c) && exp_cnt < 255) exp_cnt = exp_cnt + 1;
      @(posedge clk);
      #2;
      check_all(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      load = 1'b0; inc = 1'b0; clr = 1'b0; in_data = '0;
      exp_data = 0; exp_cnt = 0; exp_err = 0;
      #1;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; load = 1'b0; inc = 1'b0; clr = 1'b0; in_data = '0;
      exp_data = 0; exp_cnt = 0; exp_err = 0;
      #5;
      check_all("por");
      @(negedge clk);
      rst_n = 1'b1;

      // Populate state, then assert reset mid-cycle with load still active.
      cycle(1'b0, 1'b0, 1'b1, 16'h0000, "pre_clr");
      cycle(1'b1, 1'b0, 1'b0, 16'hABCD, "pre_load");
      @(negedge clk);
      load = 1'b1; in_data = 16'hABCD;
      #5;
      rst_n = 1'b0;
      exp_data = 0; exp_cnt = 0; exp_err = 0;
      #1;
      check_all("async_rst");
      @(posedge clk);
      #2;
      check_all("rst_hold");
      @(negedge clk);
      rst_n = 1'b1; load = 1'b0;

      for (int v = 255; v >= 0; v--) begin
         cycle(1'b1, 1'b0, 1'b0, 16'(v), "sweep");
      end
      check("sweep_end", int'(out_data), 0);
      cycle(1'b1, 1'b0, 1'b0, 16'h12F3, "upper_ignored");
      check("f3", int'(out_data), 8'hF3);

      cycle(1'b1, 1'b0, 1'b0, 16'h005A, "load_5a");
      cycle(1'b0, 1'b0, 1'b1, 16'hFFFF, "clr");
      check("clr_cnt1", int'(err_count), 1);
      cycle(1'b0, 1'b0, 1'b0, 16'hFFFF, "hold");
      check("clr_pulse_gone", int'(cmd_err), 0);

      for (int k = 0; k < 255; k++) begin
         cycle(1'b0, 1'b1, 1'b0, 16'(k), "inc");
      end
      check("inc_sat", int'(err_count), 255);
      check("inc_data", int'(out_data), 8'h5A);
      cycle(1'b0, 1'b1, 1'b1, 16'h0000, "both_sat");

      cycle(1'b1, 1'b0, 1'b1, 16'h0077, "load_clr");
      check("load_clr_data", int'(out_data), 8'h77);

      do_reset();
      for (int n = 0; n < 1500; n++) begin
         logic [15:0] d;
         logic l, i, c;
         d = 16'($urandom);
         l = 1'($urandom_range(0, 1));
         i = ($urandom_range(0, 3) == 0);
         c = ($urandom_range(0, 3) == 0);
         cycle(l, i, c, d, "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
